spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 46 ++++
 rtl/spi_sclk_div.sv | 52 +++++
 rtl/spi_master.sv | 193 +++++++++++++++++++
 tb/tb_spi_master.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI master. Holds the FSM state
//               encoding, the write/read bit counts, the frame length N, and
//               a helper that packs the operands into the transmit word.
//               Build option: SPI_MASTER_READBACK_EN appends RD_BITS read
//               bits to every frame and enables result capture from MISO.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int WR_BITS = 10;    // num1[3:0], num2[3:0], operacion[1:0]
    localparam int RD_BITS = 4;     // result bits clocked back from the slave

`ifdef SPI_MASTER_READBACK_EN
    localparam int N_BITS = WR_BITS + RD_BITS;
`else
    localparam int N_BITS = WR_BITS;
`endif

    // Bit counter is sized for the longest frame (14 bits).
    localparam int BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_TRANSFER = 2'd2,
        ST_GUARD    = 2'd3
    } state_t;

    // Transmit word, MSB sent first. Any read-bit slots at the bottom are
    // zero so MOSI idles low while the slave is answering.
    function automatic logic [N_BITS-1:0] frame_word(
        input logic [3:0] n1,
        input logic [3:0] n2,
        input logic [1:0] op
    );
        logic [N_BITS-1:0] w;
        w = '0;
        w[N_BITS-1 -: WR_BITS] = {n1, n2, op};
        return w;
    endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sclk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_div
// Description : Half-period timer for SLCK. Pulses tick on the last of every
//               CLK_DIV enabled clk cycles. The count is held at zero while
//               disabled and is restarted by clr so each FSM state begins a
//               fresh, full-length half-period.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               en    - count enable (FSM not idle)
//               clr   - synchronous restart (FSM changing state)
//               tick  - last cycle of the current half-period
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_div #(
    parameter int CLK_DIV = 4       // clk cycles per half-period, 1..255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == TERM);

endmodule : spi_sclk_div
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Mode-0 SPI master sending one fixed-format frame per start:
//               SETUP (T cycles, CS low, SLCK low), N bits of T-high/T-low
//               SLCK, then GUARD (T cycles, CS high). T = CLK_DIV.
//               Build option: SPI_MASTER_READBACK_EN adds 4 read bits whose
//               MISO values form resultado; without it resultado stays 0.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start               - frame request, honoured in IDLE only
//               num1, num2, operacion - operands, latched on acceptance
//               MISO                - serial data from slave
//               CS, SLCK, MOSI      - SPI bus (CS active-low, SLCK idles low)
//               busy                - frame in progress (SETUP..GUARD)
//               done                - one-cycle pulse on frame completion
//               resultado           - last received result
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic [1:0] operacion,
    input  logic       MISO,
    output logic       CS,
    output logic       SLCK,
    output logic       MOSI,
    output logic       busy,
    output logic       done,
    output logic [3:0] resultado
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(N_BITS - 1);

    state_t                 state_q, state_d;
    logic [N_BITS-1:0]      shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   sclk_q, sclk_d;
    logic                   done_q, done_d;
    logic                   w_tick;
    logic                   w_div_en;
    logic                   w_div_clr;

`ifdef SPI_MASTER_READBACK_EN
    localparam logic [BIT_CNT_W-1:0] FIRST_RD = BIT_CNT_W'(WR_BITS);
    logic [RD_BITS-1:0]     rx_q, rx_d;
    logic [RD_BITS-1:0]     res_q, res_d;
`endif

    // ------------------------------------------------------------------
    // Half-period timer. Restarted on every state change so a state never
    // inherits a partial count from the previous one.
    // ------------------------------------------------------------------
    assign w_div_en  = (state_q != ST_IDLE);
    assign w_div_clr = (state_d != state_q);

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_div_en),
        .clr   (w_div_clr),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;
`ifdef SPI_MASTER_READBACK_EN
        rx_d      = rx_q;
        res_d     = res_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d   = frame_word(num1, num2, operacion);
                    bit_cnt_d = '0;
                    sclk_d    = 1'b0;
                    state_d   = ST_SETUP;
`ifdef SPI_MASTER_READBACK_EN
                    rx_d      = '0;
`endif
                end
            end

            ST_SETUP: begin
                if (w_tick) begin
                    sclk_d    = 1'b1;       // bit 0 is always a write bit
                    bit_cnt_d = '0;
                    state_d   = ST_TRANSFER;
                end
            end

            ST_TRANSFER: begin
                if (w_tick) begin
                    if (sclk_q) begin
                        // End of high phase: fall and present the next bit.
                        sclk_d  = 1'b0;
                        shreg_d = shreg_q << 1;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = ST_GUARD;
`ifdef SPI_MASTER_READBACK_EN
                        res_d     = rx_q;
`endif
                    end else begin
                        // End of low phase: rise for the next bit. MISO is
                        // captured on this same edge for read bits.
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sclk_d    = 1'b1;
`ifdef SPI_MASTER_READBACK_EN
                        if ((bit_cnt_q + 1'b1) >= FIRST_RD) begin
                            rx_d = {rx_q[RD_BITS-2:0], MISO};
                        end
`endif
                    end
                end
            end

            ST_GUARD: begin
                if (w_tick) begin
                    shreg_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            done_q    <= done_d;
        end
    end

`ifdef SPI_MASTER_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q  <= '0;
            res_q <= '0;
        end else begin
            rx_q  <= rx_d;
            res_q <= res_d;
        end
    end

    assign resultado = res_q;
`else
    logic w_unused_miso;
    assign w_unused_miso = MISO;
    assign resultado     = 4'h0;
`endif

    // ------------------------------------------------------------------
    // Outputs. CS is decoded from the state register so reset raises it
    // immediately; MOSI is the head of the shift register, which only
    // moves at the start of a low phase.
    // ------------------------------------------------------------------
    assign CS   = !((state_q == ST_SETUP) || (state_q == ST_TRANSFER));
    assign SLCK = sclk_q;
    assign MOSI = shreg_q[N_BITS-1];
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule : spi_master
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master. Two instances run side by
//               side (CLK_DIV=4 and CLK_DIV=1). Frames are checked against a
//               timing/bit-stream model derived from the frame format: SLCK
//               shape per cycle, CS window, MOSI bits at SLCK rise, done
//               position, busy length and the returned result.
//               Honours SPI_MASTER_READBACK_EN to select the frame length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

`ifdef SPI_MASTER_READBACK_EN
    localparam int NB = 14;
    localparam bit RB = 1'b1;
`else
    localparam int NB = 10;
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a [2];
    logic [3:0] n1_a    [2];
    logic [3:0] n2_a    [2];
    logic [1:0] op_a    [2];
    logic       miso_a  [2];
    logic [1:0] cs_v, slck_v, mosi_v, busy_v, done_v;
    logic [7:0] res_v;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4)) u_dut_div4 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .num1(n1_a[0]),
        .num2(n2_a[0]), .operacion(op_a[0]), .MISO(miso_a[0]),
        .CS(cs_v[0]), .SLCK(slck_v[0]), .MOSI(mosi_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .resultado(res_v[3:0])
    );

    spi_master #(.CLK_DIV(1)) u_dut_div1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .num1(n1_a[1]),
        .num2(n2_a[1]), .operacion(op_a[1]), .MISO(miso_a[1]),
        .CS(cs_v[1]), .SLCK(slck_v[1]), .MOSI(mosi_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .resultado(res_v[7:4])
    );

    function automatic int tdiv(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete frame on instance d, with a mode-0 slave answering resp.
    // perturb scrambles the operands and start every cycle after acceptance.
    task automatic run_frame(input int d, input logic [3:0] a, input logic [3:0] b,
                             input logic [1:0] op, input logic [3:0] resp,
                             input bit perturb, input string tag);
        int         t, cyc, limit, rises, falls, dcnt, dat;
        int         sclk_err, cs_err, hold_err, stream, exp_stream;
        logic       s, prev, hi_mosi, exp_s;
        logic [3:0] rsh, res_done, exp_res;

        t          = tdiv(d);
        limit      = (2 * NB + 2) * t + 16;
        exp_stream = int'({a, b, op}) << (NB - 10);
        exp_res    = RB ? resp : 4'h0;
        rsh        = resp;
        cyc = 0; rises = 0; falls = 0; dcnt = 0; dat = -1;
        sclk_err = 0; cs_err = 0; hold_err = 0; stream = 0;
        prev = 1'b0; hi_mosi = 1'b0; res_done = 4'hx;

        n1_a[d] = a; n2_a[d] = b; op_a[d] = op;
        miso_a[d] = 1'b0;
        start_a[d] = 1'b1;
        step();
        start_a[d] = 1'b0;
        chk({tag, ":busy_rise"}, 32'(busy_v[d]), 32'd1);

        while (busy_v[d] === 1'b1 && cyc < limit) begin
            s     = slck_v[d];
            exp_s = (cyc >= t) && (cyc < t + 2 * NB * t) && ((((cyc - t) / t) % 2) == 0);
            if (s !== exp_s) sclk_err++;
            if (cs_v[d] !== 1'(cyc >= (2 * NB + 1) * t)) cs_err++;
            if (s && !prev) begin
                stream  = (stream << 1) | int'(mosi_v[d]);
                hi_mosi = mosi_v[d];
                rises++;
            end else if (s && prev && mosi_v[d] !== hi_mosi) begin
                hold_err++;
            end
            if (!s && prev) begin
                falls++;
                // After k falls the next rising edge carries bit k.
                if (falls >= 10 && falls < NB) begin
                    miso_a[d] = rsh[3];
                    rsh = rsh << 1;
                end else begin
                    miso_a[d] = 1'($urandom);
                end
            end
            if (done_v[d] === 1'b1) begin
                dcnt++;
                dat      = cyc;
                res_done = res_v[d*4 +: 4];
            end
            prev = s;
            if (perturb) begin
                n1_a[d]    = 4'($urandom);
                n2_a[d]    = 4'($urandom);
                op_a[d]    = 2'($urandom);
                start_a[d] = 1'($urandom);
            end
            step();
            cyc++;
        end
        start_a[d] = 1'b0;

        chk({tag, ":busy_len"},  32'(cyc),        32'((2 * NB + 2) * t));
        chk({tag, ":mosi"},      32'(stream),     32'(exp_stream));
        chk({tag, ":rises"},     32'(rises),      32'(NB));
        chk({tag, ":done_cnt"},  32'(dcnt),       32'd1);
        chk({tag, ":done_at"},   32'(dat),        32'((2 * NB + 1) * t));
        chk({tag, ":res_done"},  32'(res_done),   32'(exp_res));
        chk({tag, ":sclk_err"},  32'(sclk_err),   32'd0);
        chk({tag, ":cs_err"},    32'(cs_err),     32'd0);
        chk({tag, ":mosi_hold"}, 32'(hold_err),   32'd0);
        chk({tag, ":res_hold"},  32'(res_v[d*4 +: 4]), 32'(exp_res));
    endtask

    initial begin
        int k, cnt_cs, gap, dbad;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_a[i] = 1'b0; n1_a[i] = 4'h0; n2_a[i] = 4'h0;
            op_a[i] = 2'b00; miso_a[i] = 1'b0;
        end
        repeat (3) step();
        // {CS, SLCK, MOSI, busy, done, resultado}
        chk("reset_div4", 32'({cs_v[0], slck_v[0], mosi_v[0], busy_v[0], done_v[0], res_v[3:0]}), 32'h100);
        chk("reset_div1", 32'({cs_v[1], slck_v[1], mosi_v[1], busy_v[1], done_v[1], res_v[7:4]}), 32'h100);

        // First start in the same cycle reset is released.
        rst_n = 1'b1;
        run_frame(0, 4'hA, 4'h3, 2'b10, 4'hD, 1'b0, "ref_div4");
        run_frame(1, 4'hF, 4'h0, 2'b01, 4'h6, 1'b0, "ref_div1");

        // start ignored while busy, operands scrambled mid-frame.
        run_frame(0, 4'h5, 4'hC, 2'b11, 4'h9, 1'b1, "perturb_div4");
        run_frame(1, 4'h2, 4'h7, 2'b00, 4'hB, 1'b1, "perturb_div1");

        for (int i = 0; i < 3; i++) begin
            run_frame(0, 4'($urandom), 4'($urandom), 2'($urandom), 4'($urandom), 1'b0, "rand_div4");
            run_frame(1, 4'($urandom), 4'($urandom), 2'($urandom), 4'($urandom), 1'b1, "rand_div1");
        end

        // start held high: the guard (CS high while busy) lasts T cycles,
        // then one IDLE cycle samples start and the next frame begins.
        n1_a[0] = 4'h6; n2_a[0] = 4'h9; op_a[0] = 2'b01;
        start_a[0] = 1'b1;
        k = 0;
        while (done_v[0] !== 1'b1 && k < 200) begin step(); k++; end
        chk("b2b:done_seen", 32'(done_v[0]), 32'd1);
        cnt_cs = 0;
        while (busy_v[0] === 1'b1 && k < 400) begin
            if (cs_v[0] === 1'b1) cnt_cs++;
            step(); k++;
        end
        gap = 0;
        while (busy_v[0] === 1'b0 && k < 400) begin gap++; step(); k++; end
        chk("b2b:guard_cs", 32'(cnt_cs), 32'd4);
        chk("b2b:idle_gap", 32'(gap),    32'd1);
        chk("b2b:restart",  32'({busy_v[0], cs_v[0]}), 32'b10);
        start_a[0] = 1'b0;
        k = 0;
        while (busy_v[0] === 1'b1 && k < 200) begin step(); k++; end
        chk("b2b:end", 32'(busy_v[0]), 32'd0);

        // Reset in the middle of a transfer after a nonzero result.
        run_frame(0, 4'h1, 4'h8, 2'b10, 4'hE, 1'b0, "pre_rst");
        n1_a[0] = 4'hC; n2_a[0] = 4'h4; op_a[0] = 2'b11;
        start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        repeat (20) step();
        chk("rst:in_frame", 32'({busy_v[0], cs_v[0]}), 32'b10);
        #3 rst_n = 1'b0;
        #1;
        chk("rst:async", 32'({cs_v[0], slck_v[0], mosi_v[0], busy_v[0], done_v[0], res_v[3:0]}), 32'h100);
        dbad = 0;
        repeat (3) begin
            step();
            if (done_v[0] !== 1'b0 || done_v[1] !== 1'b0) dbad++;
        end
        chk("rst:no_done", 32'(dbad), 32'd0);
        rst_n = 1'b1;
        run_frame(0, 4'hA, 4'h3, 2'b10, 4'hD, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_spi_master
`default_nettype wire
